// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer with prescaled tick, pause/run control and a
// one-cycle done pulse on reaching zero.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        enable,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StPause, StRun, StExpired} state_e;

  state_e            state_q, state_d;
  logic [15:0]       digits_q, digits_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              done_q, done_d;
  logic [15:0]       load_clamped;
  logic [15:0]       digits_dec;
  logic              tick;

  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  // Ripple borrow from the least significant digit; a 0 digit wraps to 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!borrow) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

  assign load_clamped = bcd_clamp(load_val);
  assign digits_dec   = bcd_dec(digits_q);
  assign tick         = (state_q == StRun) && (presc_q == PrescMax);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    if (load) begin
      digits_d = load_clamped;
      presc_d  = '0;
      state_d  = (load_clamped != 16'h0000) ? StPause : StIdle;
    end else begin
      unique case (state_q)
        StIdle:    ;
        StPause: begin
          if (enable) state_d = StRun;
        end
        StRun: begin
          if (!enable) begin
            state_d = StPause;
          end else if (tick) begin
            presc_d  = '0;
            digits_d = digits_dec;
            if (digits_dec == 16'h0000) begin
              state_d = StExpired;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PrescW'(1);
          end
        end
        StExpired: ;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      digits_q <= 16'h0000;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == StRun);
  assign expired = (state_q == StExpired);
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with TICK_DIV=4; inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_bcd_countdown_timer;

  logic        CLOCK_50;
  logic        resetn;
  logic        load;
  logic [15:0] load_val;
  logic        enable;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        done;

  int checks = 0;
  int errors = 0;

  bcd_countdown_timer #(.TICK_DIV(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .load     (load),
    .load_val (load_val),
    .enable   (enable),
    .digits   (digits),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] d, input logic r,
                            input logic x, input logic dn);
    check({tag, ".digits"}, digits, d);
    check({tag, ".running"}, {15'd0, running}, {15'd0, r});
    check({tag, ".expired"}, {15'd0, expired}, {15'd0, x});
    check({tag, ".done"}, {15'd0, done}, {15'd0, dn});
  endtask

  initial begin
    resetn   = 1'b0;
    load     = 1'b0;
    load_val = 16'h0000;
    enable   = 1'b0;
    #3;
    check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(2);
    resetn = 1'b1;

    // Countdown 3 -> 0 with 4-cycle tick spacing
    load = 1'b1; load_val = 16'h0003; enable = 1'b1;
    cyc(1);
    check_outs("load3", 16'h0003, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    cyc(1);
    check_outs("run3", 16'h0003, 1'b1, 1'b0, 1'b0);
    cyc(3);
    check("pre_tick1", digits, 16'h0003);
    cyc(1);
    check("tick1", digits, 16'h0002);
    cyc(3);
    check("pre_tick2", digits, 16'h0002);
    cyc(1);
    check("tick2", digits, 16'h0001);
    cyc(3);
    check_outs("pre_tick3", 16'h0001, 1'b1, 1'b0, 1'b0);
    cyc(1);
    check_outs("expire", 16'h0000, 1'b0, 1'b1, 1'b1);
    cyc(1);
    check_outs("expire+1", 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc(10);
    check_outs("expire_hold", 16'h0000, 1'b0, 1'b1, 1'b0);

    // Borrow chains; load overrides EXPIRED
    load = 1'b1; load_val = 16'h1000;
    cyc(1);
    check_outs("load1000", 16'h1000, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    cyc(5);
    check("borrow1000", digits, 16'h0999);
    load = 1'b1; load_val = 16'h0100;
    cyc(1);
    check("load0100", digits, 16'h0100);
    load = 1'b0;
    cyc(5);
    check("borrow0100", digits, 16'h0099);

    // Pause two cycles after a tick; prescaler resumes from 2
    cyc(2);
    enable = 1'b0;
    cyc(1);
    check_outs("pause", 16'h0099, 1'b0, 1'b0, 1'b0);
    cyc(9);
    check_outs("pause_hold", 16'h0099, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    cyc(1);
    check_outs("resume", 16'h0099, 1'b1, 1'b0, 1'b0);
    cyc(1);
    check("resume+1", digits, 16'h0099);
    cyc(1);
    check("resume+2", digits, 16'h0098);

    // Load on a tick cycle wins over the decrement
    cyc(3);
    load = 1'b1; load_val = 16'h0050;
    cyc(1);
    check_outs("load_on_tick", 16'h0050, 1'b0, 1'b0, 1'b0);
    load = 1'b0; enable = 1'b0;
    cyc(2);
    check_outs("load_on_tick_hold", 16'h0050, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    cyc(1);
    check("pause_to_run", {15'd0, running}, 16'h0001);

    // Clamp and zero load
    load = 1'b1; load_val = 16'h00AF;
    cyc(1);
    check("clamp", digits, 16'h0099);
    load_val = 16'h0000;
    cyc(1);
    check_outs("load_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check_outs("idle", 16'h0000, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-RUN at 0002
    load = 1'b1; load_val = 16'h0003;
    cyc(1);
    load = 1'b0;
    cyc(5);
    check_outs("pre_reset", 16'h0002, 1'b1, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check_outs("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("no_done", {15'd0, done}, 16'h0000);
    end
    resetn = 1'b1;
    load = 1'b1; load_val = 16'h0007;
    cyc(1);
    check_outs("load_after_reset", 16'h0007, 1'b0, 1'b0, 1'b0);
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, CLOCK_50 cycles per countdown step (1 s at 50 MHz); legal range 2..2^26.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port load  input  1  synchronous load strobe for load_val.
REQ-005 SHALL have port load_val  input  16  four BCD digits, [15:12] most significant, [3:0] least significant.
REQ-006 SHALL have port enable  input  1  level; high = count, low = pause.
REQ-007 SHALL have port digits  output  16  current BCD count, same digit order as load_val, registered.
REQ-008 SHALL have port running  output  1  high while state is RUN.
REQ-009 SHALL have port expired  output  1  high while state is EXPIRED.
REQ-010 SHALL have port done  output  1  one-cycle registered pulse on entry to EXPIRED.

Function
REQ-011 SHALL implement states IDLE, PAUSE, RUN and EXPIRED.
REQ-012 Prescaler SHALL count 0..TICK_DIV-1, advancing only in RUN; tick is the cycle where prescaler = TICK_DIV-1, after which it wraps to 0.
REQ-013 Load SHALL set digits to load_val with each digit >9 clamped to 9, clear the prescaler, and enter PAUSE if the clamped value is nonzero, IDLE if zero.
REQ-014 Load SHALL take priority over tick, enable and the current state, including EXPIRED.
REQ-015 PAUSE with enable=1 SHALL enter RUN next cycle; prescaler resumes from its held value.
REQ-016 RUN with enable=0 SHALL enter PAUSE next cycle; prescaler and digits hold, and no decrement occurs that cycle even on a tick.
REQ-017 On a tick in RUN with enable=1, digits SHALL decrement by one in BCD on that edge, with no extra latency.
REQ-018 Borrow: a digit at 0 SHALL become 9 and borrow from the next digit (e.g. 1000 -> 0999); digits never hold values above 9.
REQ-019 A decrement that produces 0000 SHALL enter EXPIRED on the same edge, with done=1 for exactly that following cycle.
REQ-020 EXPIRED SHALL hold digits at 0000 and ignore enable until load; no wrap to 9999 ever occurs.
REQ-021 IDLE SHALL ignore enable; digits remain 0000.
REQ-022 done SHALL never be high for two consecutive cycles, and SHALL never be high outside the first cycle of EXPIRED.

Reset
REQ-023 resetn=0 SHALL immediately, without a clock edge, force state IDLE, digits=16'h0000, prescaler=0, running=0, expired=0 and done=0.
REQ-024 After resetn deasserts, the block SHALL respond to load on the first rising edge.
REQ-025 Reset asserted mid-RUN SHALL discard the count; no done pulse results.

Verification (bench uses TICK_DIV=4)
REQ-026 SHALL cover: reset, then load=1 with load_val=0x0003 and enable=1 -> PAUSE then RUN; digits 0003->0002->0001->0000 at 4-cycle spacing; done high exactly 1 cycle; expired stays 1.
REQ-027 SHALL cover: load 0x1000, run one tick -> digits 0x0999; load 0x0100 -> one tick -> 0x0099.
REQ-028 SHALL cover: enable low for 10 cycles in RUN two cycles after a tick -> digits frozen, running=0; after re-enable, next decrement occurs exactly 2 cycles after RUN is re-entered.
REQ-029 SHALL cover: load 0x0050 asserted on a tick cycle in RUN -> digits=0x0050, state PAUSE, no decrement applied.
REQ-030 SHALL cover: load 0x00AF -> digits 0x0099; load 0x0000 -> IDLE, and enable=1 produces no done.
REQ-031 SHALL cover: resetn pulsed low mid-cycle during RUN at count 0x0002 -> outputs clear asynchronously before the next edge; done never asserts.
